// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, RAM handshake state and memory arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } arb_state_t;

  localparam int ARB_TIMEOUT_W = 8;

endpackage

// File: rtl/arb_perf_ctr.sv
// Hit and stall statistics counters for the memory arbiter (built only with MEM_ARB_STATS_EN).
module arb_perf_ctr (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ihit_i,
  input  logic        dhit_i,
  input  logic        req_i,
  output logic [31:0] icnt_o,
  output logic [31:0] dcnt_o,
  output logic [31:0] stallcnt_o
);

  logic [31:0] icnt_q, dcnt_q, stall_q;
  logic [31:0] icnt_d, dcnt_d, stall_d;

  always_comb begin
    icnt_d  = icnt_q + {31'd0, ihit_i};
    dcnt_d  = dcnt_q + {31'd0, dhit_i};
    stall_d = stall_q + {31'd0, (req_i && !ihit_i && !dhit_i)};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      icnt_q  <= '0;
      dcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
      stall_q <= stall_d;
    end
  end

  assign icnt_o     = icnt_q;
  assign dcnt_o     = dcnt_q;
  assign stallcnt_o = stall_q;

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory; data has priority
// with a fetch starvation guard. Define MEM_ARB_STATS_EN to add icnt/dcnt/stallcnt outputs.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dhit,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       icnt,
  output logic [31:0]       dcnt,
  output logic [31:0]       stallcnt
`endif
);

  localparam int STRK_W = $clog2(MAX_DSTREAK + 1);

  arb_state_t               state_q, state_d;
  logic [WORD_W-1:0]        addr_q, addr_d;
  logic [WORD_W-1:0]        store_q, store_d;
  logic                     rd_q, rd_d;
  logic                     wr_q, wr_d;
  logic [STRK_W-1:0]        streak_q, streak_d;
  logic [ARB_TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                     tmo_hit, bus_fail, fetch_forced;

  assign tmo_hit      = (tmo_q == ARB_TIMEOUT_W'(TIMEOUT));
  assign bus_fail     = (ramstate == ERROR) || tmo_hit;
  assign fetch_forced = iREN && (streak_q >= STRK_W'(MAX_DSTREAK));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    store_d  = store_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    streak_d = streak_q;
    tmo_d    = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((dREN || dWEN) && !fetch_forced) begin
          state_d = DBUS;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
          rd_d    = !dWEN;
          if (!iREN)
            streak_d = '0;
          else if (streak_q < STRK_W'(MAX_DSTREAK))
            streak_d = streak_q + 1'b1;
        end else if (iREN) begin
          state_d  = IBUS;
          addr_d   = iaddr;
          store_d  = '0;
          rd_d     = 1'b1;
          wr_d     = 1'b0;
          streak_d = '0;
        end
      end
      IBUS: begin
        if (bus_fail) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          ihit    = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DBUS: begin
        // A flushed read may be dropped; a latched write must run to completion.
        if (bus_fail) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (rd_q && !dREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          dhit    = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      streak_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      streak_q <= streak_d;
      tmo_q    <= tmo_d;
    end
  end

  // RAM enables are Moore outputs of the registered state and latched op.
  assign ramREN   = (state_q == IBUS) || ((state_q == DBUS) && rd_q);
  assign ramWEN   = (state_q == DBUS) && wr_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign iload    = ihit ? ramload : '0;
  assign dload    = dhit ? ramload : '0;

`ifdef MEM_ARB_STATS_EN
  arb_perf_ctr u_perf (
    .clk_i      (CLK),
    .rst_i      (RST),
    .ihit_i     (ihit),
    .dhit_i     (dhit),
    .req_i      (iREN || dREN || dWEN),
    .icnt_o     (icnt),
    .dcnt_o     (dcnt),
    .stallcnt_o (stallcnt)
  );
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter with a simple latency-programmable RAM model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  ramstate_t   ramstate;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] icnt, dcnt, stallcnt;
`endif

  memory_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
`ifdef MEM_ARB_STATS_EN
    , .icnt(icnt), .dcnt(dcnt), .stallcnt(stallcnt)
`endif
  );

  always #5 CLK = ~CLK;

  // RAM model: mode 0 = ACCESS after lat cycles, 1 = stuck BUSY, 2 = ERROR.
  int         lat = 0;
  int         mode = 0;
  logic [3:0] rcnt = '0;
  always @(posedge CLK)
    if (ramREN || ramWEN) rcnt <= (rcnt == 4'd15) ? rcnt : rcnt + 4'd1;
    else rcnt <= '0;
  always_comb begin
    ramstate = FREE;
    if (ramREN || ramWEN) begin
      if (mode == 1) ramstate = BUSY;
      else if (mode == 2) ramstate = ERROR;
      else ramstate = (int'(rcnt) >= lat) ? ACCESS : BUSY;
    end
  end
  assign ramload = {ramaddr[15:0], ~ramaddr[15:0]};

  function automatic logic [31:0] exp_load(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
  } exp_t;
  exp_t sb[$];

  int n_tot = 0;
  int n_bad = 0;
  bit hit_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input bit is_d, input bit wr, input logic [31:0] a, input logic [31:0] s);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = a; e.store = s;
    sb.push_back(e);
  endtask

  task automatic check_hits();
    exp_t e;
    if (ihit || dhit) begin
      hit_seen = 1'b1;
      chk("hit_onehot", {31'd0, ihit && dhit}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_hit", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("hit_kind", {31'd0, dhit}, {31'd0, e.is_d});
        chk("ramaddr", ramaddr, e.addr);
        chk("load", dhit ? dload : iload, exp_load(e.addr));
        if (e.is_d) begin
          chk("ramWEN_d", {31'd0, ramWEN}, {31'd0, e.wr});
          chk("ramREN_d", {31'd0, ramREN}, {31'd0, !e.wr});
          if (e.wr) chk("ramstore", ramstore, e.store);
        end
      end
    end else begin
      chk("load_idle", iload | dload, 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    check_hits();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_hit(output int cyc);
    hit_seen = 1'b0;
    cyc = 0;
    while (!hit_seen && cyc < 60) begin
      tick();
      cyc++;
    end
    if (!hit_seen) chk("hit_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int k;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ctrl", {27'd0, ramREN, ramWEN, ihit, dhit, err}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
`ifdef MEM_ARB_STATS_EN
    chk("rst_icnt", icnt, 32'd0);
`endif
    RST = 1'b0;
    tick();

    // minimum-latency data read
    lat = 0; dREN = 1'b1; daddr = 32'h0000_0120; push(1, 0, 32'h120, 0);
    wait_hit(cyc);
    dREN = 1'b0;
    chk("dread_lat0", cyc, 32'd2);
    chk("idle_after_dhit", {31'd0, ramREN}, 32'd0);

    // fetch at 0x40, RAM answers 2 cycles after ramREN
    lat = 2; iREN = 1'b1; iaddr = 32'h40; push(0, 0, 32'h40, 0);
    wait_hit(cyc);
    iREN = 1'b0;
    chk("ifetch_lat2", cyc, 32'd4);
    chk("idle_after_ihit", {31'd0, ramREN}, 32'd0);
    tick();
    chk("no_extra_hit", sb.size(), 32'd0);

    // data priority with starvation guard: D,D,D,D then I
    lat = 0; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h100; daddr = 32'h200;
    for (int i = 0; i < 4; i++) push(1, 0, 32'h200, 0);
    push(0, 0, 32'h100, 0);
    for (int i = 0; i < 5; i++) wait_hit(cyc);
    iREN = 1'b0; dREN = 1'b0;
    chk("streak_done", sb.size(), 32'd0);
    tick();

    // write survives dWEN dropping mid-BUSY
    lat = 3; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    push(1, 1, 32'h80, 32'hDEAD_BEEF);
    tick();
    chk("wr_ramWEN", {31'd0, ramWEN}, 32'd1);
    tick();
    dWEN = 1'b0;
    wait_hit(cyc);
    chk("wr_done", sb.size(), 32'd0);
    tick();

    // flushed fetch
    lat = 5; iREN = 1'b1; iaddr = 32'h44;
    tick();
    chk("flush_ramREN_on", {31'd0, ramREN}, 32'd1);
    tick();
    iREN = 1'b0;
    #1;
    chk("flush_no_ihit", {31'd0, ihit}, 32'd0);
    tick();
    chk("flush_ramREN_off", {31'd0, ramREN}, 32'd0);
    tick();

    // RAM ERROR: immediate err, no hit
    mode = 2; iREN = 1'b1; iaddr = 32'h48;
    tick();
    chk("error_err", {31'd0, err}, 32'd1);
    chk("error_no_hit", {30'd0, ihit, dhit}, 32'd0);
    iREN = 1'b0;
    tick();
    chk("error_err_clear", {31'd0, err}, 32'd0);
    chk("error_idle", {31'd0, ramREN}, 32'd0);

    // timeout with RAM stuck BUSY on a write
    mode = 1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'h1111_2222;
    tick();
    dWEN = 1'b0;
    k = 1;
    while (!err && k < 300) begin
      tick();
      k++;
    end
    chk("timeout_cycle", k, 32'd256);
    chk("timeout_no_hit", {31'd0, dhit}, 32'd0);
    tick();
    chk("timeout_idle", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("timeout_err_clear", {31'd0, err}, 32'd0);

    // reset during DBUS
    dREN = 1'b1; daddr = 32'h500; dstore = 32'h1234_5678;
    tick();
    chk("rstbus_ramREN", {31'd0, ramREN}, 32'd1);
    RST = 1'b1;
    tick();
    chk("rstbus_ctrl", {27'd0, ramREN, ramWEN, ihit, dhit, err}, 32'd0);
    chk("rstbus_ramaddr", ramaddr, 32'd0);
    chk("rstbus_ramstore", ramstore, 32'd0);
    chk("rstbus_loads", iload | dload, 32'd0);
    dREN = 1'b0; RST = 1'b0; mode = 0; lat = 0;
    tick();

    // three fetches from reset
    for (int i = 0; i < 3; i++) begin
      iREN = 1'b1; iaddr = 32'h600 + 32'(i * 4); push(0, 0, iaddr, 0);
      wait_hit(cyc);
    end
    iREN = 1'b0;
    tick();
    chk("final_sb_empty", sb.size(), 32'd0);
`ifdef MEM_ARB_STATS_EN
    chk("stats_icnt", icnt, 32'd3);
    chk("stats_dcnt", dcnt, 32'd0);
    chk("stats_stallcnt", stallcnt, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
